// File: rtl/delay_line_sched_pkg.sv
// Shared types and limits for the kernel delay-line scheduler.
package delay_line_sched_pkg;

    typedef enum logic [1:0] {FILL, RUN, DRAIN} dls_state_t;

    localparam int DLS_MIN_DEPTH = 2;

endpackage

// File: rtl/delay_line_sched_dline.sv
// PARAKRN-wide shift-register delay line; contents carry no reset.
module delay_line #(
    parameter int DELYNUM = 6,
    parameter int PARAKRN = 4,
    parameter int DATALEN = 6
) (
    input  logic                       clk,
    input  logic                       i_valid,
    input  logic [PARAKRN*DATALEN-1:0] i_data,
    output logic [PARAKRN*DATALEN-1:0] o_tap_n,
    output logic [PARAKRN*DATALEN-1:0] o_tap_n1
);

    logic [PARAKRN*DATALEN-1:0] r_stage [DELYNUM];

    always_ff @(posedge clk) begin
        if (i_valid) begin
            r_stage[0] <= i_data;
            for (int k = 1; k < DELYNUM; k++) begin
                r_stage[k] <= r_stage[k-1];
            end
        end
    end

    assign o_tap_n  = r_stage[DELYNUM-1];
    assign o_tap_n1 = r_stage[DELYNUM-2];

endmodule

// File: rtl/delay_line_sched.sv
// Shift/zero/valid sequencing for the kernel delay line: fill, run, drain.
module delay_line_sched
    import delay_line_sched_pkg::*;
#(
    parameter int DELYNUM = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic in_ready,
    input  logic in_last,
    output logic dl_shift,
    output logic dl_zero,
    output logic out_valid,
    input  logic out_ready,
    output logic out_last,
    output logic busy
);

    localparam int CNTW = $clog2(DELYNUM + 1);
    localparam logic [CNTW-1:0] FULL  = CNTW'(DELYNUM);
    localparam logic [CNTW-1:0] LASTD = CNTW'(DELYNUM - 1);

    generate
        if (DELYNUM < DLS_MIN_DEPTH) begin : g_bad_depth
            $error("delay_line_sched: DELYNUM below minimum depth");
        end
    endgenerate

    dls_state_t      r_st;
    dls_state_t      w_st_nxt;
    logic [CNTW-1:0] r_shift_cnt;
    logic [CNTW-1:0] w_shift_nxt;
    logic [CNTW-1:0] r_drn_cnt;
    logic [CNTW-1:0] w_drn_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_st        <= FILL;
            r_shift_cnt <= '0;
            r_drn_cnt   <= '0;
        end else begin
            r_st        <= w_st_nxt;
            r_shift_cnt <= w_shift_nxt;
            r_drn_cnt   <= w_drn_nxt;
        end
    end

    always_comb begin
        in_ready    = 1'b0;
        dl_shift    = 1'b0;
        dl_zero     = 1'b0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        w_st_nxt    = r_st;
        w_shift_nxt = r_shift_cnt;
        w_drn_nxt   = r_drn_cnt;
        unique case (r_st)
            FILL: begin
                in_ready = 1'b1;
                dl_shift = in_valid;
                if (in_valid) begin
                    w_shift_nxt = r_shift_cnt + 1'b1;
                    if (in_last) begin
                        w_st_nxt = DRAIN;
                    end else if (r_shift_cnt == LASTD) begin
                        w_st_nxt = RUN;
                    end
                end
            end
            RUN: begin
                out_valid = in_valid;
                in_ready  = out_ready;
                dl_shift  = in_valid & out_ready;
                if (in_valid && out_ready && in_last) begin
                    w_st_nxt = DRAIN;
                end
            end
            DRAIN: begin
                dl_zero   = 1'b1;
                out_valid = (r_shift_cnt == FULL);
                // Short frames still travel to the taps via bubble shifts.
                dl_shift  = out_valid ? out_ready : 1'b1;
                out_last  = out_valid && (r_drn_cnt == LASTD);
                if (dl_shift) begin
                    if (r_drn_cnt == LASTD) begin
                        w_st_nxt    = FILL;
                        w_shift_nxt = '0;
                        w_drn_nxt   = '0;
                    end else begin
                        w_drn_nxt   = r_drn_cnt + 1'b1;
                        w_shift_nxt = (r_shift_cnt == FULL) ? FULL
                                                            : r_shift_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_st_nxt = FILL;
            end
        endcase
    end

    assign busy = (r_st != FILL) || (r_shift_cnt != '0);

endmodule

// File: tb/tb_delay_line_sched.sv
// Scoreboard bench: scheduler plus a real delay line, DELYNUM=6.
module tb_delay_line_sched;

    localparam int DELYNUM = 6;
    localparam int PARAKRN = 4;
    localparam int DATALEN = 6;
    localparam int W       = PARAKRN * DATALEN;

    typedef logic [W-1:0] word_t;
    typedef struct packed {
        word_t tn;
        word_t tn1;
        logic  last;
    } pair_t;

    logic  clk;
    logic  rst;
    logic  in_valid;
    logic  in_ready;
    logic  in_last;
    logic  dl_shift;
    logic  dl_zero;
    logic  out_valid;
    logic  out_ready;
    logic  out_last;
    logic  busy;
    word_t in_data;
    word_t w_dl_in;
    word_t tap_n;
    word_t tap_n1;

    delay_line_sched #(.DELYNUM(DELYNUM)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .dl_shift  (dl_shift),
        .dl_zero   (dl_zero),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy)
    );

    assign w_dl_in = dl_zero ? '0 : in_data;

    delay_line #(
        .DELYNUM (DELYNUM),
        .PARAKRN (PARAKRN),
        .DATALEN (DATALEN)
    ) u_dl (
        .clk      (clk),
        .i_valid  (dl_shift),
        .i_data   (w_dl_in),
        .o_tap_n  (tap_n),
        .o_tap_n1 (tap_n1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    errors;
    int    checks;
    int    nrdy_cnt;
    bit    ready_mode;
    bit    have_pend;
    word_t pend;
    word_t acc_s;
    pair_t exp_p;
    pair_t sb[$];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic word_t mk(input int s);
        word_t w;
        w = '0;
        if (s != 0) begin
            for (int k = 0; k < PARAKRN; k++) begin
                w[k*DATALEN +: DATALEN] = DATALEN'(s + k);
            end
        end
        return w;
    endfunction

    always @(posedge clk) begin
        #1;
        if (ready_mode) out_ready = ~out_ready;
        else            out_ready = 1'b1;
    end

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            have_pend = 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("extra_pair", out_valid, 0);
                end else begin
                    exp_p = sb.pop_front();
                    chk("pair", {tap_n, tap_n1, out_last}, exp_p);
                end
            end
            if (out_valid && !out_ready) chk("stall", dl_shift, 0);
            if (!out_valid) chk("last_idle", out_last, 0);
            if (in_ready && !in_valid) chk("noshift", {out_valid, dl_shift}, 0);
            if (in_valid && !in_ready) nrdy_cnt++;
            if (in_valid && in_ready) begin
                acc_s = in_data;
                if (have_pend) sb.push_back({pend, acc_s, 1'b0});
                if (in_last) begin
                    sb.push_back({acc_s, word_t'(0), 1'b1});
                    have_pend = 1'b0;
                end else begin
                    pend      = acc_s;
                    have_pend = 1'b1;
                end
            end
        end
    end

    task automatic send(input int first, input int len, input bit gap,
                        input bit do_last);
        bit acc;
        int cnt;
        for (int k = 0; k < len; k++) begin
            if (gap && k > DELYNUM && (k % 2) == 0) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = mk(first + k);
            in_last  = do_last && (k == len - 1);
            acc = 1'b0;
            cnt = 0;
            while (!acc && cnt < 200) begin
                @(negedge clk);
                acc = in_valid && in_ready;
                if (k >= DELYNUM) chk("mirror", in_ready, out_ready);
                if (acc) chk("lat", out_valid, (k >= DELYNUM));
                @(posedge clk);
                #1;
                cnt++;
            end
            if (!acc) chk("accept_timeout", acc, 1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 200);
        chk("idle_timeout", busy, 0);
        chk("sb_empty", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        nrdy_cnt   = 0;
        ready_mode = 1'b0;
        have_pend  = 1'b0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        in_data    = '0;
        out_ready  = 1'b1;
        #12;
        chk("rst_in_ready",  in_ready,  1);
        chk("rst_dl_shift",  dl_shift,  0);
        chk("rst_dl_zero",   dl_zero,   0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last",  out_last,  0);
        chk("rst_busy",      busy,      0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        send(1, 10, 1'b0, 1'b1);
        wait_idle();

        send(1, 3, 1'b0, 1'b1);
        wait_idle();

        ready_mode = 1'b1;
        send(1, 12, 1'b0, 1'b1);
        wait_idle();
        ready_mode = 1'b0;
        @(posedge clk);
        #1;

        send(1, 14, 1'b1, 1'b1);
        wait_idle();

        nrdy_cnt = 0;
        send(1, 7, 1'b0, 1'b1);
        send(1, 8, 1'b0, 1'b1);
        chk("b2b_drain_stall", nrdy_cnt, 6);
        wait_idle();

        send(1, 8, 1'b0, 1'b0);
        rst = 1'b1;
        #2;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy",      busy,      0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(20, 10, 1'b0, 1'b1);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
